// File: rtl/rk_mem_arbiter.sv
// rk_mem_arbiter
//   Shares one SDRAM_Controller between the CPU and the video DMA. Requests
//   are level signals sampled only in IDLE. The winner's command is held on
//   the controller port for ACCESS_CYCLES cycles. The low byte of the read
//   data is then returned with a one-cycle acknowledge.
//
// Ports
//   clk50mhz, reset_n          : clock, synchronous active-low reset
//   cpu_req/we/addr/wdata      : CPU request (read or write)
//   cpu_rdata, cpu_ack         : CPU read data register, completion pulse
//   dma_req/addr               : DMA request (always a read)
//   dma_rdata, dma_ack         : DMA read data register, completion pulse
//   mem_addr/idata/rd/we_n     : command port to SDRAM_Controller
//   mem_odata                  : read data from SDRAM_Controller
//   gnt_cpu, gnt_dma           : access in progress for that requester
module rk_mem_arbiter #(
  parameter int ACCESS_CYCLES = 6
) (
  input  logic        clk50mhz,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [14:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  input  logic        dma_req,
  input  logic [14:0] dma_addr,
  output logic [7:0]  dma_rdata,
  output logic        dma_ack,
  output logic [17:0] mem_addr,
  output logic [7:0]  mem_idata,
  output logic        mem_rd,
  output logic        mem_we_n,
  input  logic [15:0] mem_odata,
  output logic        gnt_cpu,
  output logic        gnt_dma
);

  if (ACCESS_CYCLES < 2 || ACCESS_CYCLES > 15) begin : g_bad_access_cycles
    $error("rk_mem_arbiter: ACCESS_CYCLES must be in 2..15");
  end

  localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACC, REC} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        last_dma_q;   // 1 = DMA was granted last
  logic        win_dma_q;    // winner of the current access
  logic        we_q;         // current access is a CPU write
  logic [17:0] mem_addr_q;
  logic [7:0]  mem_idata_q;
  logic        mem_rd_q;
  logic        mem_we_n_q;
  logic [7:0]  cpu_rdata_q;
  logic [7:0]  dma_rdata_q;
  logic        cpu_ack_q;
  logic        dma_ack_q;
  logic        gnt_cpu_q;
  logic        gnt_dma_q;
  logic        pick_dma_d;
  logic        unused_odata_hi;

  // Only the low byte of the controller word is used.
  assign unused_odata_hi = ^mem_odata[15:8];

  // Round-robin: on contention the requester not granted last wins.
  always_comb begin
    pick_dma_d = dma_req;
    if (dma_req && cpu_req) pick_dma_d = ~last_dma_q;
  end

  always_ff @(posedge clk50mhz) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_dma_q  <= 1'b0;
      win_dma_q   <= 1'b0;
      we_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_idata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_we_n_q  <= 1'b1;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      gnt_cpu_q   <= 1'b0;
      gnt_dma_q   <= 1'b0;
    end else begin
      cpu_ack_q <= 1'b0;
      dma_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cpu_req || dma_req) begin
            state_q   <= ACC;
            cnt_q     <= CNT_INIT;
            win_dma_q <= pick_dma_d;
            if (pick_dma_d) begin
              we_q       <= 1'b0;
              mem_addr_q <= {3'b000, dma_addr};
              mem_rd_q   <= 1'b1;
              mem_we_n_q <= 1'b1;
              gnt_dma_q  <= 1'b1;
            end else begin
              we_q       <= cpu_we;
              mem_addr_q <= {3'b000, cpu_addr};
              mem_rd_q   <= ~cpu_we;
              mem_we_n_q <= ~cpu_we;
              // idata only changes on a write so it otherwise holds its value
              if (cpu_we) mem_idata_q <= cpu_wdata;
              gnt_cpu_q  <= 1'b1;
            end
          end
        end
        ACC: begin
          if (cnt_q == 4'd0) begin
            // Edge closing the last command cycle: controller data is valid.
            state_q    <= REC;
            mem_rd_q   <= 1'b0;
            mem_we_n_q <= 1'b1;
            last_dma_q <= win_dma_q;
            if (win_dma_q) begin
              dma_rdata_q <= mem_odata[7:0];
              dma_ack_q   <= 1'b1;
            end else begin
              if (!we_q) cpu_rdata_q <= mem_odata[7:0];
              cpu_ack_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        REC: begin
          state_q   <= IDLE;
          gnt_cpu_q <= 1'b0;
          gnt_dma_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_idata = mem_idata_q;
  assign mem_rd    = mem_rd_q;
  assign mem_we_n  = mem_we_n_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign dma_ack   = dma_ack_q;
  assign gnt_cpu   = gnt_cpu_q;
  assign gnt_dma   = gnt_dma_q;

endmodule

// File: doc/rk_mem_arbiter.md
# rk_mem_arbiter

Two-port arbiter that shares the single SDRAM_Controller instance between the CPU and the video DMA. It accepts word requests from both requesters, serialises them onto the controller's rd/we_n/iaddr/idata port and holds each command for a fixed number of cycles. It then returns the low byte of the read data to the granted requester with a one-cycle acknowledge. It sits between the k580wm80a/k580wt57 bus logic and the SDRAM_Controller, and it replaces the ad-hoc vid_rd address/command mux.

## Interface
Parameters:
- ACCESS_CYCLES, 6, number of cycles a command is held on the controller port; legal range 2..15.

Ports:
- clk50mhz  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- cpu_req  in  1  CPU access request, level; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; sampled with cpu_req at grant.
- cpu_addr  in  15  CPU word address.
- cpu_wdata  in  8  CPU write data.
- cpu_rdata  out  8  CPU read data register.
- cpu_ack  out  1  one-cycle completion pulse for the CPU access.
- dma_req  in  1  DMA read request, level; held until dma_ack.
- dma_addr  in  15  DMA word address.
- dma_rdata  out  8  DMA read data register.
- dma_ack  out  1  one-cycle completion pulse for the DMA access.
- mem_addr  out  18  to SDRAM_Controller iaddr.
- mem_idata  out  8  to SDRAM_Controller idata.
- mem_rd  out  1  to SDRAM_Controller rd, active-high.
- mem_we_n  out  1  to SDRAM_Controller we_n, active-low.
- mem_odata  in  16  from SDRAM_Controller odata.
- gnt_cpu  out  1  high while the CPU access is in progress.
- gnt_dma  out  1  high while the DMA access is in progress.

## Operation
- States: IDLE, ACC, REC.
- IDLE:
  - No request pending: stay in IDLE.
  - Otherwise select a winner, latch its address, write data and direction, and go to ACC. Load cnt = ACCESS_CYCLES-1.
- Arbitration when only one request is pending: that requester wins.
- Arbitration when both are pending: the requester not granted last wins (round-robin). last_gnt resets to CPU, so the first contested slot goes to DMA.
- ACC:
  - mem_addr = {3'b000, latched addr}.
  - CPU read: mem_rd=1, mem_we_n=1.
  - CPU write: mem_rd=0, mem_we_n=0, mem_idata = latched wdata.
  - DMA access is always a read.
  - cnt decrements each cycle. At cnt==0, capture mem_odata[7:0] into the winner's rdata register (reads only), update last_gnt, and go to REC.
- REC (one cycle):
  - mem_rd=0, mem_we_n=1.
  - Pulse the winner's ack.
  - Return to IDLE.
- Requests are sampled only in IDLE. A req still high in the cycle after ack is treated as a new request.
- rdata registers hold their value until the next read completion for that port. A write leaves cpu_rdata unchanged.
- gnt_cpu / gnt_dma are high in ACC and REC for the winner, and never both at once.
- mem_addr and mem_idata hold their last value outside ACC.
- Bits [17:15] of mem_addr are always 0.

## Timing
- Reset values (sync, reset_n low at a clock edge):
  - state=IDLE, last_gnt=CPU.
  - mem_rd=0, mem_we_n=1, mem_addr=0, mem_idata=0.
  - cpu_rdata=0, dma_rdata=0.
  - cpu_ack=0, dma_ack=0, gnt_cpu=0, gnt_dma=0.
- All outputs are registered.
- Request seen in IDLE at edge 0:
  - Command outputs valid in cycles 1..N (N = ACCESS_CYCLES).
  - mem_odata is sampled at the edge closing cycle N.
  - ack and rdata are valid in cycle N+1.
  - IDLE in cycle N+2.
- Throughput: one access per N+2 cycles. A pending request is granted in cycle N+2, and its command starts in cycle N+3.
- Requests arriving during ACC/REC wait; they are not lost, because req is level and held.
- A request dropped before grant is ignored. Dropping req after grant does not abort the access; ack is still issued.
- Reset mid-access: the access is abandoned, no ack is issued, and the command is deasserted from the next cycle.
- The cnt width is 4 bits. ACCESS_CYCLES outside 2..15 is illegal; simulation asserts on it.

## Test plan
- CPU read, N=6: cpu_req=1, cpu_we=0, cpu_addr=15'h1234 at edge 0; mem_odata=16'hAB5A -> mem_addr=18'h01234 and mem_rd=1 in cycles 1–6; cpu_ack=1 in cycle 7 only; cpu_rdata=8'h5A; dma_rdata unchanged.
- CPU write: cpu_we=1, cpu_addr=15'h7FFF, cpu_wdata=8'hC3 -> mem_addr=18'h07FFF, mem_idata=8'hC3, mem_we_n=0 and mem_rd=0 in cycles 1–6; cpu_ack in cycle 7; cpu_rdata keeps its prior value.
- Simultaneous first requests after reset: both req high at edge 0 -> DMA granted (gnt_dma cycles 1–7, dma_ack cycle 7); CPU command starts cycle 9, cpu_ack cycle 15.
- Both requesters hold req continuously for 4 accesses -> grants alternate DMA, CPU, DMA, CPU; ack pulses at cycles 7, 15, 23, 31; gnt_cpu and gnt_dma are never high together.
- Reset mid-access: reset_n low at cycle 3 of a CPU read -> cycle 4 has mem_rd=0, all acks 0, rdata=0; after release with cpu_req still high, a fresh 8-cycle access completes normally.
- DMA req dropped in cycle 2 of its access -> dma_ack still pulses in cycle 7 with the correct dma_rdata; no second DMA access follows.
